// File: rtl/wb_queue_if.sv
// Write-back collector bus: four producer result slots in, two register-file
// write ports, the forwarding lookup and the status flags out.
interface wb_queue_if;
  logic [4:0]  alu1_d;
  logic [31:0] alu1_data;
  logic [4:0]  alu2_d;
  logic [31:0] alu2_data;
  logic [4:0]  mem1_d;
  logic [31:0] mem1_data;
  logic [4:0]  mem2_d;
  logic [31:0] mem2_data;

  logic [4:0]  w1addr;
  logic [31:0] w1;
  logic        w1en;
  logic [4:0]  w2addr;
  logic [31:0] w2;
  logic        w2en;

  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic        stall;
  logic        overflow;

  modport master (
    output alu1_d, alu1_data, alu2_d, alu2_data,
           mem1_d, mem1_data, mem2_d, mem2_data, fwd_addr,
    input  w1addr, w1, w1en, w2addr, w2, w2en,
           fwd_hit, fwd_data, stall, overflow
  );

  modport slave (
    input  alu1_d, alu1_data, alu2_d, alu2_data,
           mem1_d, mem1_data, mem2_d, mem2_data, fwd_addr,
    output w1addr, w1, w1en, w2addr, w2, w2en,
           fwd_hit, fwd_data, stall, overflow
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: coalesces up to four results per cycle into an in-order
// FIFO, drains two per cycle to the register file and forwards pending values.
module wb_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  wb_queue_if.slave  bus
);

  localparam int          NSLOT    = 4;
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 4);

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          stall_q, stall_d;
  logic          overflow_q, overflow_d;

  logic [4:0]       slot_d    [NSLOT];
  logic [31:0]      slot_data [NSLOT];
  logic [NSLOT-1:0] keep;
  logic [NSLOT-1:0] push_en;
  logic             any_valid;
  logic [2:0]       push_cnt;
  logic [1:0]       pop_cnt;

  logic [AW-1:0] rd_ptr_nx;
  logic          head_v, pair_v, pair_same;
  logic          fwd_hit_c;
  logic [31:0]   fwd_data_c;

  always_comb begin
    slot_d[0]    = bus.alu1_d;
    slot_data[0] = bus.alu1_data;
    slot_d[1]    = bus.alu2_d;
    slot_data[1] = bus.alu2_data;
    slot_d[2]    = bus.mem1_d;
    slot_data[2] = bus.mem1_data;
    slot_d[3]    = bus.mem2_d;
    slot_data[3] = bus.mem2_data;
  end

  // A slot survives only if no younger slot this cycle targets the same register.
  always_comb begin
    keep      = '0;
    any_valid = 1'b0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      keep[s]   = (slot_d[s] != 5'd0);
      any_valid = any_valid | keep[s];
      for (int unsigned j = s + 1; j < NSLOT; j++) begin
        if (slot_d[j] == slot_d[s]) keep[s] = 1'b0;
      end
    end
  end

  always_comb begin
    push_en  = keep & {NSLOT{~stall_q}};
    push_cnt = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      push_cnt = push_cnt + 3'(push_en[s]);
    end
  end

  always_comb begin
    head_v    = (count_q != '0);
    pair_v    = (count_q >= (AW+1)'(2));
    rd_ptr_nx = rd_ptr_q + AW'(1);
    pair_same = pair_v && (addr_q[rd_ptr_q] == addr_q[rd_ptr_nx]);
    pop_cnt   = pair_v ? 2'd2 : (head_v ? 2'd1 : 2'd0);
  end

  // Same-register head pair: only the younger write goes out, both entries retire.
  always_comb begin
    bus.w1en   = head_v & ~pair_same;
    bus.w1addr = head_v ? addr_q[rd_ptr_q] : '0;
    bus.w1     = head_v ? data_q[rd_ptr_q] : '0;
    bus.w2en   = pair_v;
    bus.w2addr = pair_v ? addr_q[rd_ptr_nx] : '0;
    bus.w2     = pair_v ? data_q[rd_ptr_nx] : '0;
  end

  // Ascending scan from the head so the youngest matching entry wins.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count_q) && (bus.fwd_addr != 5'd0) &&
          (addr_q[rd_ptr_q + AW'(i)] == bus.fwd_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = data_q[rd_ptr_q + AW'(i)];
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_data_c;
  assign bus.stall    = stall_q;
  assign bus.overflow = overflow_q;

  always_comb begin : push_blk
    logic [AW-1:0] wp;
    addr_d = addr_q;
    data_d = data_q;
    wp     = wr_ptr_q;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (push_en[s]) begin
        addr_d[wp] = slot_d[s];
        data_d[wp] = slot_data[s];
        wp         = wp + AW'(1);
      end
    end
    wr_ptr_d   = wp;
    rd_ptr_d   = rd_ptr_q + AW'(pop_cnt);
    count_d    = count_q - (AW+1)'(pop_cnt) + (AW+1)'(push_cnt);
    stall_d    = (count_d > STALL_TH);
    overflow_d = overflow_q | (stall_q & any_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: hand-computed vector table for the directed cases, then
// random traffic checked against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_queue_if bus();

  wb_queue #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [4:0]  d [4];
    logic [31:0] x [4];
    logic [4:0]  fa;
  } in_t;

  typedef struct {
    in_t         in;
    logic        w1en;
    logic [4:0]  w1a;
    logic [31:0] w1;
    logic        w2en;
    logic [4:0]  w2a;
    logic [31:0] w2;
    logic        hit;
    logic [31:0] fd;
    logic        stall;
    logic        ovf;
  } vec_t;

  ent_t       mq[$];
  bit         m_stall = 0;
  bit         m_ovf   = 0;
  logic [4:0] cur_fa  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk_in(input int d1, input int x1, input int d2, input int x2,
                                input int d3, input int x3, input int d4, input int x4,
                                input int fa);
    in_t r;
    r.d[0] = 5'(d1); r.x[0] = 32'(x1);
    r.d[1] = 5'(d2); r.x[1] = 32'(x2);
    r.d[2] = 5'(d3); r.x[2] = 32'(x3);
    r.d[3] = 5'(d4); r.x[3] = 32'(x4);
    r.fa   = 5'(fa);
    return r;
  endfunction

  function automatic vec_t mk(input int d1, input int x1, input int d2, input int x2,
                              input int d3, input int x3, input int d4, input int x4,
                              input int fa,
                              input int e1en, input int e1a, input int e1,
                              input int e2en, input int e2a, input int e2,
                              input int ehit, input int efd, input int est, input int eov);
    vec_t v;
    v.in    = mk_in(d1, x1, d2, x2, d3, x3, d4, x4, fa);
    v.w1en  = 1'(e1en); v.w1a = 5'(e1a); v.w1 = 32'(e1);
    v.w2en  = 1'(e2en); v.w2a = 5'(e2a); v.w2 = 32'(e2);
    v.hit   = 1'(ehit); v.fd  = 32'(efd);
    v.stall = 1'(est);  v.ovf = 1'(eov);
    return v;
  endfunction

  // Drive one cycle of stimulus, advance the reference queue, sample after the edge.
  task automatic apply(input in_t v);
    ent_t tmp[$];
    bit   any;
    bit   seen;
    int   n;
    bus.alu1_d = v.d[0]; bus.alu1_data = v.x[0];
    bus.alu2_d = v.d[1]; bus.alu2_data = v.x[1];
    bus.mem1_d = v.d[2]; bus.mem1_data = v.x[2];
    bus.mem2_d = v.d[3]; bus.mem2_data = v.x[3];
    bus.fwd_addr = v.fa;
    cur_fa = v.fa;
    any = 0;
    for (int s = 0; s < 4; s++) if (v.d[s] != 0) any = 1;
    n = (mq.size() >= 2) ? 2 : mq.size();
    repeat (n) void'(mq.pop_front());
    if (m_stall) begin
      if (any) m_ovf = 1;
    end else begin
      for (int s = 3; s >= 0; s--) begin
        if (v.d[s] != 0) begin
          seen = 0;
          foreach (tmp[k]) if (tmp[k].a == v.d[s]) seen = 1;
          if (!seen) tmp.push_front('{a: v.d[s], d: v.x[s]});
        end
      end
      foreach (tmp[k]) mq.push_back(tmp[k]);
    end
    m_stall = (mq.size() > DEPTH - 4);
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string t, input vec_t v);
    chk({t, ".w1en"},   32'(bus.w1en),     32'(v.w1en));
    chk({t, ".w1addr"}, 32'(bus.w1addr),   32'(v.w1a));
    chk({t, ".w1"},     bus.w1,            v.w1);
    chk({t, ".w2en"},   32'(bus.w2en),     32'(v.w2en));
    chk({t, ".w2addr"}, 32'(bus.w2addr),   32'(v.w2a));
    chk({t, ".w2"},     bus.w2,            v.w2);
    chk({t, ".fwd_hit"}, 32'(bus.fwd_hit), 32'(v.hit));
    chk({t, ".fwd_data"}, bus.fwd_data,    v.fd);
    chk({t, ".stall"},  32'(bus.stall),    32'(v.stall));
    chk({t, ".overflow"}, 32'(bus.overflow), 32'(v.ovf));
  endtask

  task automatic check_model(input string t);
    vec_t e;
    int   sz;
    e    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sz   = mq.size();
    if (sz >= 1) begin
      e.w1en = 1; e.w1a = mq[0].a; e.w1 = mq[0].d;
    end
    if (sz >= 2) begin
      e.w2en = 1; e.w2a = mq[1].a; e.w2 = mq[1].d;
      if (mq[0].a == mq[1].a) e.w1en = 0;
    end
    for (int k = sz - 1; k >= 0; k--) begin
      if (!e.hit && cur_fa != 0 && mq[k].a == cur_fa) begin
        e.hit = 1; e.fd = mq[k].d;
      end
    end
    e.stall = m_stall;
    e.ovf   = m_ovf;
    check_vec(t, e);
  endtask

  vec_t tbl[$];
  vec_t zero_v;
  in_t  rin;

  initial begin
    rst = 1'b1;
    rin = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 3);
    bus.alu1_d = '0; bus.alu1_data = '0; bus.alu2_d = '0; bus.alu2_data = '0;
    bus.mem1_d = '0; bus.mem1_data = '0; bus.mem2_d = '0; bus.mem2_data = '0;
    bus.fwd_addr = 5'd3;
    cur_fa = 5'd3;
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_vec("reset", zero_v);

    //            alu1      alu2      mem1      mem2      fa  w1en a  w1    w2en a  w2    hit fd    st ov
    tbl.push_back(mk(5, 'h11, 0, 0,    0, 0,    0, 0,    5,  1, 5, 'h11, 0, 0, 0,    1, 'h11, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    5,  0, 0, 0,    0, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(0, 'hFF, 7, 'hA,  0, 0,    7, 'hB,  7,  1, 7, 'hB,  0, 0, 0,    1, 'hB,  0, 0));
    tbl.push_back(mk(1, 1,    2, 2,    3, 3,    4, 4,    3,  1, 1, 1,    1, 2, 2,    1, 3,    0, 0));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    4,  1, 3, 3,    1, 4, 4,    1, 4,    0, 0));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    4,  0, 0, 0,    0, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 'h21, 2, 'h22, 9, 'h1,  0, 0,    9,  1, 1, 'h21, 1, 2, 'h22, 1, 'h1,  0, 0));
    tbl.push_back(mk(9, 'h2,  0, 0,    0, 0,    0, 0,    9,  0, 9, 'h1,  1, 9, 'h2,  1, 'h2,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    9,  0, 0, 0,    0, 0, 0,    0, 0,    0, 0));
    tbl.push_back(mk(1, 'h31, 2, 'h32, 3, 'h33, 4, 'h34, 0,  1, 1, 'h31, 1, 2, 'h32, 0, 0,    0, 0));
    tbl.push_back(mk(5, 'h35, 6, 'h36, 7, 'h37, 8, 'h38, 1,  1, 3, 'h33, 1, 4, 'h34, 0, 0,    1, 0));
    tbl.push_back(mk(10,'h40, 11,'h41, 12,'h42, 13,'h43, 13, 1, 5, 'h35, 1, 6, 'h36, 0, 0,    0, 1));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    8,  1, 7, 'h37, 1, 8, 'h38, 1, 'h38, 0, 1));
    tbl.push_back(mk(0, 0,    0, 0,    0, 0,    0, 0,    8,  0, 0, 0,    0, 0, 0,    0, 0,    0, 1));

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      check_vec($sformatf("v%0d", i), tbl[i]);
    end

    // Async reset with five entries queued, in the middle of a clock period.
    apply(mk_in(1, 'h51, 2, 'h52, 3, 'h53, 4, 'h54, 5));
    apply(mk_in(5, 'h55, 6, 'h56, 7, 'h57, 0, 0, 5));
    chk("prerst.stall",   32'(bus.stall),   32'd1);
    chk("prerst.fwd_hit", 32'(bus.fwd_hit), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.w1en",     32'(bus.w1en),     32'd0);
    chk("arst.w2en",     32'(bus.w2en),     32'd0);
    chk("arst.fwd_hit",  32'(bus.fwd_hit),  32'd0);
    chk("arst.stall",    32'(bus.stall),    32'd0);
    chk("arst.overflow", 32'(bus.overflow), 32'd0);
    mq.delete();
    m_stall = 0;
    m_ovf   = 0;
    @(negedge clk);
    rst = 1'b0;
    apply(mk_in(20, 'h55, 0, 0, 0, 0, 0, 0, 20));
    check_vec("postrst", mk(0, 0, 0, 0, 0, 0, 0, 0, 20, 1, 20, 'h55, 0, 0, 0, 1, 'h55, 0, 0));
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 20));
    check_vec("postrst.drain", mk(0, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic on a small register range so coalescing and stalls are frequent.
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < 4; s++) begin
        rin.d[s] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 6)) : 5'd0;
        rin.x[s] = $urandom;
      end
      rin.fa = 5'($urandom_range(0, 6));
      apply(rin);
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back collector between the result producers (two ALU lanes, two data-memory load lanes) and the register file write ports.
- Accepts up to four (dest, data) results per cycle and drops writes to $0.
- Coalesces same-register writes within a cycle and buffers results in an in-order FIFO.
- Drains up to two writes per cycle and offers a forwarding lookup so the register read stage sees pending values.

Parameters:
- DEPTH, 8, FIFO entries of {addr[4:0], data[31:0]}; power of two, minimum 4.
- AW, 3, log2(DEPTH) pointer width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu1_d  in  5  ALU lane 1 destination; 0 = no write.
- alu1_data  in  32  ALU lane 1 result.
- alu2_d  in  5  ALU lane 2 destination; 0 = no write.
- alu2_data  in  32  ALU lane 2 result.
- mem1_d  in  5  load lane 1 destination; 0 = no write.
- mem1_data  in  32  load lane 1 data.
- mem2_d  in  5  load lane 2 destination; 0 = no write.
- mem2_data  in  32  load lane 2 data.
- w1addr  out  5  write port 1 address (older write).
- w1  out  32  write port 1 data.
- w1en  out  1  write port 1 valid.
- w2addr  out  5  write port 2 address (younger write).
- w2  out  32  write port 2 data.
- w2en  out  1  write port 2 valid.
- fwd_addr  in  5  forwarding lookup register number.
- fwd_hit  out  1  a pending write to fwd_addr exists.
- fwd_data  out  32  data of the youngest pending write to fwd_addr.
- stall  out  1  registered back-pressure to the decoder.
- overflow  out  1  sticky: results were dropped.

Behaviour:
- Reset (async): FIFO empty, count=0, rd/wr pointers 0, stall=0, overflow=0. With the FIFO empty, w1en=w2en=0, w1addr=w2addr=0, w1=w2=0, fwd_hit=0 and fwd_data=0.
- Slot order, oldest to youngest: alu1, alu2, mem1, mem2.
- A slot is valid iff its d is non-zero.
- Intra-cycle coalescing: if two or more valid slots share a d, only the youngest is kept.
- Surviving slots are pushed at posedge in slot order into consecutive entries at wr_ptr. Push count is 0..4.
- Write ports are combinational from the FIFO head:
  - w1 is driven from entry rd_ptr when count>=1.
  - w2 is driven from entry rd_ptr+1 when count>=2.
- Head-pair coalescing: if count>=2 and both head entries have the same addr, then w1en=0, w2en=1 with the younger data, and both entries pop.
- Pops per posedge equal the number of head entries presented (0, 1 or 2). The register file consumes w1/w2 on the same edge.
- Latency: a result presented before edge N is visible on w1/w2 after edge N and retired at edge N+1 if at most 1 entry was ahead of it.
- count_next = count - pops + pushes. Simultaneous push and pop in one cycle is legal.
- Pointers wrap modulo DEPTH.
- stall (registered) = 1 when count_next > DEPTH-4, i.e. fewer than 4 free entries after this edge.
- While stall=1, all input slots are ignored (no push). If any slot is valid while stall=1, overflow is set and stays set until rst.
- Forwarding: combinational search of all occupied entries, youngest first, for addr==fwd_addr.
  - fwd_addr=0 never hits.
  - On a miss, fwd_hit=0 and fwd_data=0.
  - Entries pushed at the current edge are not visible until after that edge.
- Ordering guarantee: writes to the same register leave in push order. A later write is never issued on an earlier cycle or an older port than an earlier write to that register.
- Reset mid-operation clears the FIFO immediately. Pending writes are discarded, not drained.

Test Plan:
- Single write: alu1_d=5, alu1_data=0x11 for one cycle, others 0 -> after edge 1: w1en=1, w1addr=5, w1=0x11, w2en=0, fwd_addr=5 gives hit/0x11; after edge 2: FIFO empty, w1en=0.
- $0 and coalescing: alu1_d=0 (data 0xFF), alu2_d=7 (0xA), mem2_d=7 (0xB) -> exactly one entry {7,0xB}; w1addr=7, w1=0xB.
- Four writes, drain two per cycle: slots d=1,2,3,4 with data 1..4 -> cycle 1 ports (1,2), cycle 2 ports (3,4), cycle 3 empty.
- Head-pair coalescing: cycle A alu1_d=9 (0x1), cycle B alu1_d=9 (0x2) with the FIFO pre-held so both sit at the head -> w1en=0, w2en=1, w2addr=9, w2=0x2.
- Fill and overflow (DEPTH=8): push 4 distinct regs per cycle for 3 cycles -> stall=1 once count>4; a valid slot while stall=1 sets overflow=1 and count is unchanged by it; overflow stays 1 after the FIFO drains.
- Async reset: assert rst mid-cycle with 5 entries queued -> w1en, w2en, fwd_hit, stall and overflow go 0 immediately, without a clock edge; the first push after deassertion appears at entry 0.
